// File: rtl/reset_sequencer.sv
// Reset synchroniser and sequencer: synchronises board reset, holds,
// then releases N active-low resets in order with a fixed gap.
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int N_OUTPUTS   = 4,
    parameter int MIN_ASSERT  = 8,
    parameter int RELEASE_GAP = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sw_rst_req,
    output logic [N_OUTPUTS-1:0] srst_n,
    output logic                 rst_done
);

    localparam int CNT_MAX = (MIN_ASSERT > RELEASE_GAP) ? MIN_ASSERT : RELEASE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(N_OUTPUTS + 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "reset_sequencer: SYNC_STAGES must be >= 2");
    end
    if (N_OUTPUTS < 1) begin : g_bad_nout
        $fatal(1, "reset_sequencer: N_OUTPUTS must be >= 1");
    end
    if (MIN_ASSERT < 1) begin : g_bad_min
        $fatal(1, "reset_sequencer: MIN_ASSERT must be >= 1");
    end
    if (RELEASE_GAP < 1) begin : g_bad_gap
        $fatal(1, "reset_sequencer: RELEASE_GAP must be >= 1");
    end

    typedef enum logic [1:0] {
        RESET,
        HOLD,
        RELEASE,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_OUTPUTS-1:0] srst_q, srst_d;
    logic                 done_q, done_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 rst_sync;

    // Async clear, ones shifted in only after rst_n is released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET;
            cnt_q   <= '0;
            idx_q   <= '0;
            srst_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            srst_q  <= srst_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        srst_d  = srst_q;
        done_d  = done_q;
        unique case (state_q)
            RESET: begin
                if (rst_sync) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == CNT_W'(MIN_ASSERT - 1)) begin
                    srst_d[0] = 1'b1;
                    idx_d     = IDX_W'(1);
                    cnt_d     = '0;
                    state_d   = (N_OUTPUTS == 1) ? DONE : RELEASE;
                    done_d    = (N_OUTPUTS == 1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (cnt_q == CNT_W'(RELEASE_GAP - 1)) begin
                    for (int i = 0; i < N_OUTPUTS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            srst_d[i] = 1'b1;
                        end
                    end
                    idx_d = idx_q + 1'b1;
                    cnt_d = '0;
                    if (idx_q == IDX_W'(N_OUTPUTS - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
            end
            default: state_d = RESET;
        endcase
        // Software request restarts the hold phase; ignored until synchronised
        if (sw_rst_req && (state_q != RESET)) begin
            srst_d  = '0;
            done_d  = 1'b0;
            cnt_d   = '0;
            idx_d   = '0;
            state_d = HOLD;
        end
    end

    assign srst_n   = srst_q;
    assign rst_done = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: default instance plus a
// minimal-parameter instance sharing rst_n and sw_rst_req.
`timescale 1ns/1ps
module tb_reset_sequencer;

    logic       clk;
    logic       rst_n;
    logic       sw_rst_req;
    logic [3:0] srst_n;
    logic       rst_done;
    logic [0:0] srst2;
    logic       done2;

    reset_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_rst_req(sw_rst_req),
        .srst_n    (srst_n),
        .rst_done  (rst_done)
    );

    reset_sequencer #(
        .SYNC_STAGES(3),
        .N_OUTPUTS  (1),
        .MIN_ASSERT (1),
        .RELEASE_GAP(4)
    ) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_rst_req(sw_rst_req),
        .srst_n    (srst2),
        .rst_done  (done2)
    );

    typedef struct {
        int         e;
        logic [3:0] s;
        logic       d;
        logic [3:0] sm;
        bit         c2;
        logic       s2;
        logic       d2;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   ecnt   = 0;
    event chk_ev;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) ecnt <= ecnt + 1;

    // Monitor: compares each expectation on its edge, or immediately for async checks
    always begin
        exp_t x;
        @(negedge clk or chk_ev);
        while (q.size() > 0 && q[0].e <= ecnt) begin
            x = q.pop_front();
            checks++;
            if ((((srst_n ^ x.s) & x.sm) !== 4'h0) || (rst_done !== x.d) ||
                (x.c2 && ((srst2[0] !== x.s2) || (done2 !== x.d2)))) begin
                errors++;
                $display("FAIL %s edge=%0d got srst_n=%b done=%b dut2=%b/%b exp srst_n=%b mask=%b done=%b dut2=%b/%b",
                         x.nm, ecnt, srst_n, rst_done, srst2, done2,
                         x.s, x.sm, x.d, x.s2, x.d2);
            end
        end
    end

    task automatic push_e(input int e, input logic [3:0] s, input logic d,
                          input logic [3:0] sm, input string nm);
        exp_t x;
        x.e = e; x.s = s; x.d = d; x.sm = sm;
        x.c2 = 1'b0; x.s2 = 1'b0; x.d2 = 1'b0; x.nm = nm;
        q.push_back(x);
    endtask

    task automatic push_a(input string nm);
        exp_t x;
        x.e = -1; x.s = 4'h0; x.d = 1'b0; x.sm = 4'hF;
        x.c2 = 1'b1; x.s2 = 1'b0; x.d2 = 1'b0; x.nm = nm;
        q.push_front(x);
        -> chk_ev;
    endtask

    // hold_e: edge on which HOLD starts with cnt=0; hold2_e likewise for dut2
    task automatic push_range(input int from_e, input int to_e, input int hold_e,
                              input bit c2, input int hold2_e, input string nm);
        exp_t x;
        int   n;
        for (int e = from_e; e <= to_e; e++) begin
            n = (e - hold_e < 8) ? 0 : ((e - hold_e - 8) / 4 + 1);
            if (n > 4) n = 4;
            x.e  = e;
            x.s  = 4'((1 << n) - 1);
            x.d  = (n == 4);
            x.sm = 4'hF;
            x.c2 = c2;
            x.s2 = ((e - hold2_e) >= 1);
            x.d2 = ((e - hold2_e) >= 1);
            x.nm = nm;
            q.push_back(x);
        end
    endtask

    task automatic wait_until(input int e);
        while (ecnt < e) @(negedge clk);
    endtask

    initial begin
        int base;
        int e0;
        int c;
        int n;
        rst_n      = 1'b0;
        sw_rst_req = 1'b0;
        #1 push_a("reset_state");

        // power-on
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = ecnt;
        push_range(base + 1, base + 24, base + 3, 1'b1, base + 4, "poweron");
        wait_until(base + 24);

        // async pulse mid-sequence
        rst_n = 1'b0;
        #1 push_a("reassert");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = ecnt;
        push_range(base + 1, base + 16, base + 3, 1'b1, base + 4, "pre_pulse");
        wait_until(base + 16);
        #1 rst_n = 1'b0;
        #1 push_a("mid_pulse");
        #0.5 rst_n = 1'b1;
        base = ecnt;
        push_range(base + 1, base + 24, base + 3, 1'b1, base + 4, "rerun");
        wait_until(base + 24);

        // sw pulse from DONE
        sw_rst_req = 1'b1;
        base = ecnt + 1;
        push_range(base, base + 21, base, 1'b0, 0, "sw_pulse");
        wait_until(base);
        sw_rst_req = 1'b0;
        wait_until(base + 21);

        // sw held 20 cycles during RELEASE
        sw_rst_req = 1'b1;
        base = ecnt + 1;
        push_range(base, base + 12, base, 1'b0, 0, "sw_pre");
        wait_until(base);
        sw_rst_req = 1'b0;
        wait_until(base + 12);
        sw_rst_req = 1'b1;
        c = base + 32;
        push_range(base + 13, c + 21, c, 1'b0, 0, "sw_held");
        wait_until(c);
        sw_rst_req = 1'b0;
        wait_until(c + 21);

        // deassert 1 ps before an edge
        rst_n = 1'b0;
        #1 push_a("rr_assert_a");
        repeat (2) @(negedge clk);
        e0 = ecnt + 1;
        #4.999 rst_n = 1'b1;
        for (int e = e0; e <= e0 + 9; e++) push_e(e, 4'h0, 1'b0, 4'hF, "rr_early_a");
        push_e(e0 + 10, 4'h0, 1'b0, 4'hE, "rr_win_a");
        push_e(e0 + 11, 4'h1, 1'b0, 4'hF, "rr_late_a");
        wait_until(e0 + 11);

        // deassert 45 ps after an edge
        rst_n = 1'b0;
        #1 push_a("rr_assert_b");
        repeat (2) @(negedge clk);
        c = ecnt;
        @(posedge clk);
        #0.045 rst_n = 1'b1;
        e0 = c + 1;
        for (int e = e0 + 1; e <= e0 + 9; e++) push_e(e, 4'h0, 1'b0, 4'hF, "rr_early_b");
        push_e(e0 + 10, 4'h0, 1'b0, 4'hE, "rr_win_b");
        push_e(e0 + 11, 4'h1, 1'b0, 4'hF, "rr_late_b");
        wait_until(e0 + 11);

        n = 0;
        while (q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
